// File: rtl/dsd_decimator.sv
// Third-order CIC decimator: 1-bit DSD stream (0 = +1, 1 = -1) to 16-bit signed PCM.
// Scaling is such that a constant density d settles to pcm = 16384 * d.
module dsd_decimator #(
    parameter int LOG2R = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bit_en,
    input  logic               dsd_in,
    output logic signed [15:0] pcm,
    output logic               pcm_valid
);

    localparam int R  = 1 << LOG2R;
    localparam int W  = 3 * LOG2R + 2;
    localparam int SH = 3 * LOG2R - 14;

    localparam logic signed [W-1:0] PCM_MAX = W'(32767);
    localparam logic signed [W-1:0] PCM_MIN = -PCM_MAX;

    logic [W-1:0]       i1, i2, i3;
    logic [W-1:0]       s, d1, d2, d3;
    logic [LOG2R-1:0]   cnt;
    logic               tick;
    logic               comb_en;

    logic [W-1:0]        x;
    logic [W-1:0]        c1, c2, c3;
    logic signed [W-1:0] shifted;
    logic signed [15:0]  y_clamped;

    assign x = dsd_in ? {W{1'b1}} : W'(1);

    // Comb differences wrap modulo 2^W; W is wide enough that c3 is exact.
    always_comb begin
        c1        = s - d1;
        c2        = c1 - d2;
        c3        = c2 - d3;
        shifted   = $signed(c3) >>> SH;
        y_clamped = shifted[15:0];
        if (shifted > PCM_MAX) begin
            y_clamped = 16'sd32767;
        end else if (shifted < PCM_MIN) begin
            y_clamped = -16'sd32767;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i1        <= '0;
            i2        <= '0;
            i3        <= '0;
            cnt       <= '0;
            tick      <= 1'b0;
            comb_en   <= 1'b0;
            s         <= '0;
            d1        <= '0;
            d2        <= '0;
            d3        <= '0;
            pcm       <= '0;
            pcm_valid <= 1'b0;
        end else begin
            // Integrators and phase counter only advance on enabled bits.
            if (bit_en) begin
                i1  <= i1 + x;
                i2  <= i2 + i1;
                i3  <= i3 + i2;
                cnt <= cnt + LOG2R'(1);
            end

            // Tick -> snapshot -> comb is a fixed two-edge pipeline, independent of bit_en.
            tick    <= bit_en && (cnt == LOG2R'(R - 1));
            comb_en <= tick;
            if (tick) begin
                s <= i3;
            end

            pcm_valid <= comb_en;
            if (comb_en) begin
                d1  <= s;
                d2  <= c1;
                d3  <= c2;
                pcm <= y_clamped;
            end
        end
    end

endmodule
